rr_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 single-bit mux channel. Four requesters compete for one output line. The block grants one requester at a time, drives the mux select, and gates the selected data onto `O`. Tenure ends when the holder drops its request or exceeds a configurable hold limit. It sits between the requester bank and the shared mux datapath.

---
 rtl/rr_mux_arbiter_pkg.sv | 19 +
 rtl/rr_mux_arbiter_pick.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 91 +++++++++
 tb/tb_rr_mux_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
package rr_mux_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: first set bit of req_m searching last+1 .. last (mod NREQ).
module rr_pick
  import rr_mux_pkg::*;
(
  input  logic [NREQ-1:0] req_m,
  input  logic [SELW-1:0] last,
  output logic            any,
  output logic [SELW-1:0] win
);

  logic [SELW-1:0] w_idx;

  // Walk the search order backwards so the nearest candidate after last overwrites the rest.
  always_comb begin
    any   = 1'b0;
    win   = last;
    w_idx = last;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      w_idx = last + SELW'(k);
      if (req_m[w_idx]) begin
        any = 1'b1;
        win = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux; tenure ends on release or hold limit.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] I,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            valid,
  output logic            O
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_last;
  logic            r_valid;
  logic [HCW-1:0]  r_hold;

  logic            w_timeout;
  logic            w_release;
  logic [NREQ-1:0] w_req_m;
  logic            w_any;
  logic [SELW-1:0] w_win;

  assign w_timeout = (r_hold == HCW'(MAX_HOLD - 1));
  assign w_release = ~req[r_sel] | w_timeout;

  // Timeout re-arbitrates over everyone so a lone holder is simply re-granted.
  assign w_req_m = (r_state == GRANT && !w_timeout) ? (req & ~r_gnt) : req;

  rr_pick u_pick (
    .req_m (w_req_m),
    .last  (r_last),
    .any   (w_any),
    .win   (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= '1;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hold <= '0;
          if (w_any) begin
            r_state <= GRANT;
            r_gnt   <= onehot(w_win);
            r_sel   <= w_win;
            r_last  <= w_win;
            r_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_hold <= '0;
            if (w_any) begin
              r_gnt  <= onehot(w_win);
              r_sel  <= w_win;
              r_last <= w_win;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_valid <= 1'b0;
            end
          end else begin
            r_hold <= r_hold + HCW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign O     = r_valid ? I[r_sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter with MAX_HOLD=4: vector table plus reset/rotation sequence.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] I;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       O;

  rr_mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .I     (I),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .O     (O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] i;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;
    bit         comb;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic add(input logic [3:0] r, input logic [3:0] i, input logic [3:0] g,
                     input logic [1:0] s, input logic v, input logic o, input bit c,
                     input string nm);
    vec_t t;
    t.req = r; t.i = i; t.gnt = g; t.sel = s; t.valid = v; t.o = o; t.comb = c; t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic expect_out(input logic [3:0] g, input logic [1:0] s, input logic v,
                            input logic o, input string nm);
    exp_t e;
    e.gnt = g; e.sel = s; e.valid = v; e.o = o; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      if ({gnt, sel, valid, O} !== {e.gnt, e.sel, e.valid, e.o}) begin
        n_err++;
        $display("FAIL %s: got gnt=%b sel=%0d valid=%b O=%b, want gnt=%b sel=%0d valid=%b O=%b",
                 e.name, gnt, sel, valid, O, e.gnt, e.sel, e.valid, e.o);
      end
    end
  endtask

  // Drives one vector; clocked vectors are sampled 1ns after the edge, comb ones 1ns after drive.
  task automatic apply(input vec_t v);
    req = v.req;
    I   = v.i;
    expect_out(v.gnt, v.sel, v.valid, v.o, v.name);
    if (v.comb) #1;
    else begin
      @(posedge clk);
      #1;
    end
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [1:0] idx;

    //      req      I        gnt      sel   v     O     comb  name
    add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "idle_no_req");
    add(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, "single_req1_grant");
    add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "O_follows_I1_low");
    add(4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "O_ignores_I0");
    add(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, "O_follows_I1_high");
    add(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, "idle_return_sel_kept");
    add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, "rr_wrap_to_0");
    add(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "release_to_idle");
    add(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, "grant_req2");
    add(4'b1101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, "req2_held_midtenure_ignored");
    add(4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, "vol_release_to_3");
    add(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, "idle_sel_stays_3");
    for (int k = 0; k < 10; k++)
      add(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, "lone_timeout_steady");
    add(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "lone_release_idle");

    rst_n = 1'b0;
    req   = '0;
    I     = '0;
    #3;
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0, "reset_state");
    check_out();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      v = vecs[n];
      apply(v);
    end

    // Mid-tenure asynchronous reset under full contention, then rotation from requester 0.
    v.req = 4'b1111; v.i = 4'b1010; v.gnt = 4'b0010; v.sel = 2'd1; v.valid = 1'b1;
    v.o = 1'b1; v.comb = 1'b0; v.name = "contend_from_last0";
    apply(v);
    v.name = "contend_hold";
    apply(v);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0, "async_reset_immediate");
    check_out();
    @(posedge clk);
    #1;
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0, "reset_held_over_edge");
    check_out();
    rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      idx     = 2'((c / 4) % 4);
      v.req   = 4'b1111;
      v.i     = 4'b1010;
      v.gnt   = 4'b0001 << idx;
      v.sel   = idx;
      v.valid = 1'b1;
      v.o     = idx[0];
      v.comb  = 1'b0;
      v.name  = $sformatf("rotation_c%0d", c);
      apply(v);
    end

    v.req = 4'b0000; v.i = 4'b1010; v.gnt = 4'b0000; v.sel = 2'd0; v.valid = 1'b0;
    v.o = 1'b0; v.comb = 1'b0; v.name = "timeout_no_req_idle";
    apply(v);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
